regfile_wb_arbiter: RTL

//  Shares the single regfile write port between two writeback requesters:
//  ALU (A) and load unit (M). Each requester has a small FIFO.
//  A round-robin arbiter drains the FIFOs onto rd_wren/rd_addr/rd_data.
//  A 32-entry pending scoreboard reports read-after-write hazards for rs1/rs2.

---
 rtl/regfile_wb_if.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_if.sv
// Writeback request channels (ALU, load) plus the registered regfile write port.
interface regfile_wb_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          rd_wren;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;

    modport master (
        output a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        input  a_ready, m_ready, rd_wren, rd_addr, rd_data
    );

    modport slave (
        input  a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        output a_ready, m_ready, rd_wren, rd_addr, rd_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter (ALU/load FIFOs) with a pending-write hazard scoreboard.
// Optional macro WB_BYPASS_EN adds rs1_fwd_o/rs2_fwd_o forwarding from the write port.
module regfile_wb_arbiter #(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    regfile_wb_if.slave   bus,
    input  logic          iss_valid_i,
    input  logic [AW-1:0] iss_addr_i,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o
`ifdef WB_BYPASS_EN
    ,
    output logic          rs1_fwd_o,
    output logic          rs2_fwd_o
`endif
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int EW   = AW + DW;
    localparam int NREG = 1 << AW;
    localparam logic [PW:0]   PTR_INC   = {{PW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};

    // Index 0 is the ALU side, index 1 the load side.
    logic [EW-1:0]   mem_q    [2][FIFO_DEPTH];
    logic [PW:0]     wr_ptr_q [2];
    logic [PW:0]     rd_ptr_q [2];
    logic [EW-1:0]   in_s     [2];
    logic [1:0]      empty_s;
    logic [1:0]      full_s;
    logic [1:0]      push_s;
    logic [1:0]      pop_s;
    logic [EW-1:0]   head_s;
    logic            prio_m_q, prio_m_d;
    logic            rd_wren_q, rd_wren_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic [NREG-1:0] pending_q, pending_d;

    assign in_s[0]     = {bus.a_addr, bus.a_data};
    assign in_s[1]     = {bus.m_addr, bus.m_data};
    assign bus.a_ready = ~full_s[0] & ~rst;
    assign bus.m_ready = ~full_s[1] & ~rst;
    assign push_s      = {bus.m_valid & bus.m_ready, bus.a_valid & bus.a_ready};
    assign head_s      = pop_s[1] ? mem_q[1][rd_ptr_q[1][PW-1:0]] : mem_q[0][rd_ptr_q[0][PW-1:0]];

    // FIFO occupancy flags from the registered pointers (extra wrap bit separates full from empty).
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            empty_s[s] = (wr_ptr_q[s] == rd_ptr_q[s]);
            full_s[s]  = (wr_ptr_q[s][PW] != rd_ptr_q[s][PW]) &&
                         (wr_ptr_q[s][PW-1:0] == rd_ptr_q[s][PW-1:0]);
        end
    end

    // Round-robin grant: priority only flips when both sides were competing.
    always_comb begin
        pop_s    = 2'b00;
        prio_m_d = prio_m_q;
        if (!empty_s[0] && !empty_s[1]) begin
            if (prio_m_q) begin
                pop_s = 2'b10;
            end else begin
                pop_s = 2'b01;
            end
            prio_m_d = ~prio_m_q;
        end else if (!empty_s[1]) begin
            pop_s = 2'b10;
        end else if (!empty_s[0]) begin
            pop_s = 2'b01;
        end else begin
            pop_s = 2'b00;
        end
    end

    // Write port next state; an x0 entry is consumed without a write.
    always_comb begin
        rd_wren_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if ((pop_s != 2'b00) && (head_s[EW-1:DW] != ADDR_ZERO)) begin
            rd_wren_d = 1'b1;
            rd_addr_d = head_s[EW-1:DW];
            rd_data_d = head_s[DW-1:0];
        end else begin
            rd_wren_d = 1'b0;
        end
    end

    // Scoreboard: clear on commit, then set on issue so a newer producer wins.
    always_comb begin
        pending_d = pending_q;
        if (rd_wren_q) begin
            pending_d[rd_addr_q] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (iss_valid_i && (iss_addr_i != ADDR_ZERO)) begin
            pending_d[iss_addr_i] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= {(PW+1){1'b0}};
                rd_ptr_q[s] <= {(PW+1){1'b0}};
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    mem_q[s][e] <= {EW{1'b0}};
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push_s[s]) begin
                    mem_q[s][wr_ptr_q[s][PW-1:0]] <= in_s[s];
                    wr_ptr_q[s] <= wr_ptr_q[s] + PTR_INC;
                end
                if (pop_s[s]) begin
                    rd_ptr_q[s] <= rd_ptr_q[s] + PTR_INC;
                end
            end
        end
    end

    // Arbiter priority, registered write port and pending bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_m_q  <= 1'b1;
            rd_wren_q <= 1'b0;
            rd_addr_q <= ADDR_ZERO;
            rd_data_q <= {DW{1'b0}};
            pending_q <= {NREG{1'b0}};
        end else begin
            prio_m_q  <= prio_m_d;
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            pending_q <= pending_d;
        end
    end

    assign bus.rd_wren = rd_wren_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.rd_data = rd_data_q;

`ifdef WB_BYPASS_EN
    assign rs1_fwd_o  = rd_wren_q & (rd_addr_q == rs1_addr_i) & (rs1_addr_i != ADDR_ZERO);
    assign rs2_fwd_o  = rd_wren_q & (rd_addr_q == rs2_addr_i) & (rs2_addr_i != ADDR_ZERO);
    assign rs1_busy_o = pending_q[rs1_addr_i] & ~rs1_fwd_o;
    assign rs2_busy_o = pending_q[rs2_addr_i] & ~rs2_fwd_o;
`else
    assign rs1_busy_o = pending_q[rs1_addr_i];
    assign rs2_busy_o = pending_q[rs2_addr_i];
`endif
endmodule
